grid_judge: RTL and testbench
=============================

Name: grid_judge

Overview:
- Reads back the nine 2-bit cell registers produced by the board-writing block and judges the game state: in progress, P1 win, P2 win, or tie.
- Scans the eight winning lines, one line per cycle, from a snapshot taken on a start pulse.
- Reports the outcome, the index of the winning line, and an illegal-cell flag, with a one-cycle done pulse.
- Sits between the board-writing block and the game-control FSM; the controller pulses start after every accepted move.

Parameters:
- P1_CODE, 2'b01, cell value owned by player 1
- P2_CODE, 2'b10, cell value owned by player 2

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  request a judgement; sampled only in IDLE
- clear  in  1  synchronous abort; also clears the held results
- grid_A1..grid_C3  in  2 each  cell values (00 empty, P1_CODE, P2_CODE, 11 illegal)
- busy  out  1  high while in SCAN
- done  out  1  one-cycle pulse when the result registers are valid
- outcome  out  2  00 in progress, 01 P1 win, 10 P2 win, 11 tie
- win_line  out  4  winning line index 0-7; 4'hF means none
- err  out  1  at least one snapshot cell was 2'b11

Behaviour:
- Reset is rst: asynchronous, active-low. Clock is clk, rising edge.
- Reset values: state IDLE, busy 0, done 0, outcome 00, win_line 4'hF, err 0, snapshot all 00, line_idx 0.
- clear (synchronous, highest priority after reset): go to IDLE, busy 0, done 0, outcome 00, win_line 4'hF, err 0. This applies in any state, including mid-scan.
- States:
  - IDLE -> SCAN when start=1.
  - SCAN -> DONE on the first winning line, or after line 7.
  - DONE -> IDLE unconditionally.
- On the IDLE start edge:
  - Snapshot all nine cells; later changes on the grid inputs do not affect the scan.
  - Set line_idx to 0.
  - Compute err and the empty flag from the snapshot. Cells equal to 11 count as empty and never win.
- Line order:
  - 0 A1-A2-A3, 1 B1-B2-B3, 2 C1-C2-C3
  - 3 A1-B1-C1, 4 A2-B2-C2, 5 A3-B3-C3
  - 6 A1-B2-C3, 7 A3-B2-C1
- A line wins when all three cells are equal and the value is P1_CODE or P2_CODE.
- Each SCAN cycle evaluates the line at line_idx:
  - Win: outcome = owner code (01/10), win_line = line_idx, go to DONE.
  - No win and line_idx == 7: outcome = 11 if there are no empty cells, else 00; win_line = 4'hF; go to DONE.
  - Otherwise: line_idx increments.
- Illegal boards with both players holding a line report the first line in scan order; err stays 0 unless a cell is 11.
- Latency: start sampled at edge E. A first win on line k is registered at edge E+k+1. done is high from edge E+k+1 to E+k+2. With no win, k = 7, so the maximum start-to-done is 8 edges.
- busy is high from edge E to the DONE edge. done is high only in DONE.
- start is ignored in SCAN and DONE; it is not queued.
- outcome, win_line and err are updated only at the transition into DONE (plus the snapshot-time err). They hold until the next completed scan, clear, or reset. For err, "completed" means it is updated on the start edge.
- Simultaneous start and clear: clear wins, and no scan begins.

Decomposition:
- Package ttt_pkg:
  - cell codes EMPTY/P1/P2/ILLEGAL
  - outcome codes IN_PROG/P1_WIN/P2_WIN/TIE
  - line index constants L_ROW_A..L_DIAG_ANTI, NO_LINE = 4'hF
  - square index constants 1-9 shared with the board writer
- Sub-module ttt_line_check: combinational; three 2-bit cells in, win and owner[1:0] out. Instantiated once and fed by a line_idx mux over the snapshot.

Test Plan:
- Empty board, start -> busy for 8 cycles, done at edge E+8, outcome 00, win_line F, err 0.
- A1=A2=A3=01 -> done at E+1, outcome 01, win_line 0, busy high for exactly one cycle.
- A3=B2=C1=10, others mixed with no other line -> done at E+8, outcome 10, win_line 7.
- Full board, no line (01,10,01 / 01,10,10 / 10,01,01) -> outcome 11, win_line F. Repeat with C3=11 -> outcome 00, err 1.
- Start, then change A1..A3 to 01 during SCAN -> result reflects the snapshot (outcome 00). Start pulses during SCAN are ignored.
- clear at E+3 mid-scan -> IDLE next edge, no done pulse, outcome 00, win_line F. rst low mid-scan -> outputs return to reset values immediately.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe encodings: cell codes, outcomes,
// line indices, square indices and the judge FSM states.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    P1      = 2'b01,
    P2      = 2'b10,
    ILLEGAL = 2'b11
  } cell_e;

  typedef enum logic [1:0] {
    IN_PROG = 2'b00,
    P1_WIN  = 2'b01,
    P2_WIN  = 2'b10,
    TIE     = 2'b11
  } outcome_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } judge_state_e;

  localparam logic [3:0] L_ROW_A     = 4'd0;
  localparam logic [3:0] L_ROW_B     = 4'd1;
  localparam logic [3:0] L_ROW_C     = 4'd2;
  localparam logic [3:0] L_COL_1     = 4'd3;
  localparam logic [3:0] L_COL_2     = 4'd4;
  localparam logic [3:0] L_COL_3     = 4'd5;
  localparam logic [3:0] L_DIAG      = 4'd6;
  localparam logic [3:0] L_DIAG_ANTI = 4'd7;
  localparam logic [3:0] NO_LINE     = 4'hF;

  localparam int SQ_A1 = 1;
  localparam int SQ_A2 = 2;
  localparam int SQ_A3 = 3;
  localparam int SQ_B1 = 4;
  localparam int SQ_B2 = 5;
  localparam int SQ_B3 = 6;
  localparam int SQ_C1 = 7;
  localparam int SQ_C2 = 8;
  localparam int SQ_C3 = 9;

  // Illegal cells behave like empty ones for the tie decision.
  function automatic logic is_open(input logic [1:0] c);
    return (c == EMPTY) || (c == ILLEGAL);
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational check of one three-cell line for a win.
// owner carries the winning cell code, 00 when no win.
module ttt_line_check
  import ttt_pkg::*;
#(
  parameter logic [1:0] P1_CODE = 2'b01,
  parameter logic [1:0] P2_CODE = 2'b10
) (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  output logic       win,
  output logic [1:0] owner
);

  logic same;
  logic player;

  assign same   = (a == b) && (b == c);
  assign player = (a == P1_CODE) || (a == P2_CODE);
  assign win    = same && player;
  assign owner  = win ? a : 2'b00;

endmodule

// File: rtl/grid_judge.sv
// Snapshots the board on start and scans the eight lines,
// one per cycle, reporting win/tie/in-progress and errors.
module grid_judge
  import ttt_pkg::*;
#(
  parameter logic [1:0] P1_CODE = 2'b01,
  parameter logic [1:0] P2_CODE = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clear,
  input  logic [1:0] grid_A1,
  input  logic [1:0] grid_A2,
  input  logic [1:0] grid_A3,
  input  logic [1:0] grid_B1,
  input  logic [1:0] grid_B2,
  input  logic [1:0] grid_B3,
  input  logic [1:0] grid_C1,
  input  logic [1:0] grid_C2,
  input  logic [1:0] grid_C3,
  output logic       busy,
  output logic       done,
  output logic [1:0] outcome,
  output logic [3:0] win_line,
  output logic       err
);

  judge_state_e state_q;
  judge_state_e state_d;

  logic [1:0] grid [1:9];
  logic [1:0] snap [1:9];
  logic [2:0] line_idx;
  logic       open_q;
  logic       ill_d;
  logic       open_d;

  logic [1:0] ca;
  logic [1:0] cb;
  logic [1:0] cc;
  logic       lwin;
  logic [1:0] lowner;
  logic       last;

  assign grid[SQ_A1] = grid_A1;
  assign grid[SQ_A2] = grid_A2;
  assign grid[SQ_A3] = grid_A3;
  assign grid[SQ_B1] = grid_B1;
  assign grid[SQ_B2] = grid_B2;
  assign grid[SQ_B3] = grid_B3;
  assign grid[SQ_C1] = grid_C1;
  assign grid[SQ_C2] = grid_C2;
  assign grid[SQ_C3] = grid_C3;

  always_comb begin
    ill_d  = 1'b0;
    open_d = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      ill_d  = ill_d | (grid[i] == ILLEGAL);
      open_d = open_d | is_open(grid[i]);
    end
  end

  always_comb begin
    ca = snap[SQ_A1];
    cb = snap[SQ_A2];
    cc = snap[SQ_A3];
    unique case ({1'b0, line_idx})
      L_ROW_A: begin
        ca = snap[SQ_A1]; cb = snap[SQ_A2]; cc = snap[SQ_A3];
      end
      L_ROW_B: begin
        ca = snap[SQ_B1]; cb = snap[SQ_B2]; cc = snap[SQ_B3];
      end
      L_ROW_C: begin
        ca = snap[SQ_C1]; cb = snap[SQ_C2]; cc = snap[SQ_C3];
      end
      L_COL_1: begin
        ca = snap[SQ_A1]; cb = snap[SQ_B1]; cc = snap[SQ_C1];
      end
      L_COL_2: begin
        ca = snap[SQ_A2]; cb = snap[SQ_B2]; cc = snap[SQ_C2];
      end
      L_COL_3: begin
        ca = snap[SQ_A3]; cb = snap[SQ_B3]; cc = snap[SQ_C3];
      end
      L_DIAG: begin
        ca = snap[SQ_A1]; cb = snap[SQ_B2]; cc = snap[SQ_C3];
      end
      L_DIAG_ANTI: begin
        ca = snap[SQ_A3]; cb = snap[SQ_B2]; cc = snap[SQ_C1];
      end
      default: ;
    endcase
  end

  ttt_line_check #(
    .P1_CODE(P1_CODE),
    .P2_CODE(P2_CODE)
  ) u_line (
    .a    (ca),
    .b    (cb),
    .c    (cc),
    .win  (lwin),
    .owner(lowner)
  );

  assign last = (line_idx == 3'd7);
  assign busy = (state_q == S_SCAN);
  assign done = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN;
      S_SCAN:  if (lwin || last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i <= 9; i++) snap[i] <= 2'b00;
      line_idx <= 3'd0;
      open_q   <= 1'b0;
      outcome  <= IN_PROG;
      win_line <= NO_LINE;
      err      <= 1'b0;
    end else if (clear) begin
      outcome  <= IN_PROG;
      win_line <= NO_LINE;
      err      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int i = 1; i <= 9; i++) snap[i] <= grid[i];
            line_idx <= 3'd0;
            open_q   <= open_d;
            err      <= ill_d;
          end
        end
        S_SCAN: begin
          if (lwin) begin
            outcome  <= (lowner == P1_CODE) ? P1_WIN : P2_WIN;
            win_line <= {1'b0, line_idx};
          end else if (last) begin
            outcome  <= open_q ? IN_PROG : TIE;
            win_line <= NO_LINE;
          end else begin
            line_idx <= line_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_judge.sv
// Scoreboard bench for grid_judge: directed boards,
// expected results queued at start, checked on done.
module tb_grid_judge;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clear;
  logic [17:0] bd;
  logic        busy;
  logic        done;
  logic [1:0]  outcome;
  logic [3:0]  win_line;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bcnt = 0;

  typedef struct {
    logic [1:0] oc;
    logic [3:0] wl;
    logic       er;
    int         lat;
    int         sc;
  } exp_t;

  exp_t q[$];
  exp_t me;

  localparam logic [17:0] B_EMPTY = 18'b00_00_00_00_00_00_00_00_00;
  localparam logic [17:0] B_ROWA  = 18'b01_01_01_00_00_00_00_00_00;
  localparam logic [17:0] B_ANTI  = 18'b01_01_10_00_10_01_10_00_00;
  localparam logic [17:0] B_TIE   = 18'b01_10_01_01_10_10_10_01_01;
  localparam logic [17:0] B_ERR   = 18'b01_10_01_01_10_10_10_01_11;
  localparam logic [17:0] B_ILL   = 18'b00_00_00_00_00_00_00_00_11;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  grid_judge dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .clear   (clear),
    .grid_A1 (bd[17:16]),
    .grid_A2 (bd[15:14]),
    .grid_A3 (bd[13:12]),
    .grid_B1 (bd[11:10]),
    .grid_B2 (bd[9:8]),
    .grid_B3 (bd[7:6]),
    .grid_C1 (bd[5:4]),
    .grid_C2 (bd[3:2]),
    .grid_C3 (bd[1:0]),
    .busy    (busy),
    .done    (done),
    .outcome (outcome),
    .win_line(win_line),
    .err     (err)
  );

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", n, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (rst) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          me = q.pop_front();
          chk("outcome", int'(outcome), int'(me.oc));
          chk("win_line", int'(win_line), int'(me.wl));
          chk("err", int'(err), int'(me.er));
          chk("latency", cyc - me.sc, me.lat);
          chk("busy_cycles", bcnt, me.lat);
        end
        bcnt = 0;
      end else if (busy) begin
        bcnt++;
      end else begin
        bcnt = 0;
      end
    end else begin
      bcnt = 0;
    end
  end

  task automatic go(input bit push, input logic [1:0] oc,
                    input logic [3:0] wl, input logic er,
                    input int lat);
    exp_t e;
    @(posedge clk);
    #1;
    start = 1'b1;
    if (push) begin
      e.oc  = oc;
      e.wl  = wl;
      e.er  = er;
      e.lat = lat;
      e.sc  = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", q.size(), 0);
    q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [17:0] b, input logic [1:0] oc,
                     input logic [3:0] wl, input logic er,
                     input int lat);
    bd = b;
    go(1'b1, oc, wl, er, lat);
    drain();
  endtask

  task automatic idle_out(input string n, input bit er);
    chk({n, "_busy"}, int'(busy), 0);
    chk({n, "_done"}, int'(done), 0);
    chk({n, "_outcome"}, int'(outcome), 0);
    chk({n, "_win_line"}, int'(win_line), 15);
    chk({n, "_err"}, int'(err), int'(er));
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    bd    = B_EMPTY;
    #12;
    idle_out("reset", 1'b0);
    rst = 1'b1;

    run(B_EMPTY, 2'b00, 4'hF, 1'b0, 8);
    run(B_ROWA,  2'b01, 4'h0, 1'b0, 1);
    run(B_ANTI,  2'b10, 4'h7, 1'b0, 8);
    run(B_TIE,   2'b11, 4'hF, 1'b0, 8);
    run(B_ERR,   2'b00, 4'hF, 1'b1, 8);

    // grid edits and start pulses during SCAN are ignored
    bd = B_EMPTY;
    go(1'b1, 2'b00, 4'hF, 1'b0, 8);
    repeat (2) @(posedge clk);
    #1;
    bd    = B_ROWA;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    chk("held_outcome", int'(outcome), 0);

    // clear mid-scan drops held win and snapshot err
    run(B_ROWA, 2'b01, 4'h0, 1'b0, 1);
    bd = B_ILL;
    go(1'b0, 2'b00, 4'h0, 1'b0, 0);
    chk("scan_err", int'(err), 1);
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    idle_out("clear", 1'b0);
    repeat (10) @(posedge clk);
    #1;

    // start and clear together: clear wins
    run(B_ROWA, 2'b01, 4'h0, 1'b0, 1);
    start = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    clear = 1'b0;
    idle_out("start_clear", 1'b0);
    repeat (10) @(posedge clk);
    #1;

    // asynchronous reset mid-scan
    run(B_ANTI, 2'b10, 4'h7, 1'b0, 8);
    bd = B_ILL;
    go(1'b0, 2'b00, 4'h0, 1'b0, 0);
    @(posedge clk);
    #1;
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    idle_out("async_rst", 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    run(B_ROWA, 2'b01, 4'h0, 1'b0, 1);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
